// File: rtl/regfile_write_arbiter_pkg.sv
// Shared cpu definitions for the register-file write path.
package regfile_write_arbiter_pkg;

    localparam int REG_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int DROP_W   = 8;

    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

    // One register-file write, as produced by the write-back stage.
    typedef struct packed {
        logic                we;
        logic [REG_ID_W-1:0] rd_id;
        logic [DATA_W-1:0]   data;
    } rf_wr_t;

    // Saturating increment for the stale-drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        logic [DROP_W-1:0] r;
        if (v == DROP_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_late_write_queue.sv
// In-order queue of late semaphore write-backs with per-entry valid bits,
// invalidate-by-id and id-match vectors for hazard lookup.
module late_write_queue #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 4,
    parameter int QDEPTH = 4,
    parameter int PTR_W  = $clog2(QDEPTH),
    parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic              push_valid,
    input  logic [ID_W-1:0]   push_id,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              inv_en,
    input  logic [ID_W-1:0]   inv_id,
    input  logic [ID_W-1:0]   q1_id,
    input  logic [ID_W-1:0]   q2_id,
    output logic              head_valid,
    output logic [ID_W-1:0]   head_id,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic [QDEPTH-1:0] inv_match,
    output logic [QDEPTH-1:0] q1_match,
    output logic [QDEPTH-1:0] q2_match
);

    logic [ID_W-1:0]   id_r   [QDEPTH];
    logic [DATA_W-1:0] data_r [QDEPTH];
    logic [QDEPTH-1:0] valid_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Per-entry id comparison against the invalidate id and both hazard queries.
    always_comb begin
        inv_match = {QDEPTH{1'b0}};
        q1_match  = {QDEPTH{1'b0}};
        q2_match  = {QDEPTH{1'b0}};
        for (int i = 0; i < QDEPTH; i++) begin
            inv_match[i] = valid_r[i] && (id_r[i] == inv_id);
            q1_match[i]  = valid_r[i] && (id_r[i] == q1_id);
            q2_match[i]  = valid_r[i] && (id_r[i] == q2_id);
        end
    end

    assign head_valid = valid_r[rd_ptr_r];
    assign head_id    = id_r[rd_ptr_r];
    assign head_data  = data_r[rd_ptr_r];
    assign count      = count_r;

    // Storage, valid bits, pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r  <= {QDEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                id_r[i]   <= {ID_W{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (inv_en) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (inv_match[i]) begin
                        valid_r[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (push) begin
                valid_r[wr_ptr_r] <= push_valid;
                id_r[wr_ptr_r]    <= push_id;
                data_r[wr_ptr_r]  <= push_data;
                wr_ptr_r          <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner: pipeline write-back has priority, late
// semaphore writes are queued and drained in idle cycles, stale late writes
// are discarded, and decode can query pending writes for RAW stalls.
module regfile_write_arbiter #(
    parameter int DATA_W = regfile_write_arbiter_pkg::DATA_W,
    parameter int ID_W   = regfile_write_arbiter_pkg::REG_ID_W,
    parameter int QDEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wb_reg_write,
    input  logic [ID_W-1:0]            wb_rd_id,
    input  logic [DATA_W-1:0]          wb_regfile_writeback,
    input  logic                       sema_wr_valid,
    output logic                       sema_wr_ready,
    input  logic [ID_W-1:0]            sema_wr_rd_id,
    input  logic [DATA_W-1:0]          sema_wr_data,
    input  logic [ID_W-1:0]            q_rs1_id,
    input  logic [ID_W-1:0]            q_rs2_id,
    output logic                       q_rs1_pending,
    output logic                       q_rs2_pending,
    output logic                       rf_we,
    output logic [ID_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(QDEPTH):0]    queue_count,
    output logic [7:0]                 drop_count
);

    import regfile_write_arbiter_pkg::*;

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic              accept_s;
    logic              pop_s;
    logic              push_valid_s;
    logic              head_valid_s;
    logic [ID_W-1:0]   head_id_s;
    logic [DATA_W-1:0] head_data_s;
    logic [CNT_W-1:0]  count_s;
    logic [QDEPTH-1:0] inv_match_s;
    logic [QDEPTH-1:0] q1_match_s;
    logic [QDEPTH-1:0] q2_match_s;
    logic              drop_evt_s;

    logic              we_nxt_s;
    logic [ID_W-1:0]   waddr_nxt_s;
    logic [DATA_W-1:0] wdata_nxt_s;

    logic              rf_we_r;
    logic [ID_W-1:0]   rf_waddr_r;
    logic [DATA_W-1:0] rf_wdata_r;
    logic [7:0]        drop_count_r;

    // Handshake, pop decision and staleness of the incoming late write.
    always_comb begin
        sema_wr_ready = (count_s < CNT_W'(QDEPTH));
        accept_s      = sema_wr_valid && sema_wr_ready;
        pop_s         = !wb_reg_write && (count_s != {CNT_W{1'b0}});
        push_valid_s  = !(wb_reg_write && (sema_wr_rd_id == wb_rd_id));
        drop_evt_s    = wb_reg_write && ((|inv_match_s) || (accept_s && !push_valid_s));
    end

    late_write_queue #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rstn       (rstn),
        .push       (accept_s),
        .push_valid (push_valid_s),
        .push_id    (sema_wr_rd_id),
        .push_data  (sema_wr_data),
        .pop        (pop_s),
        .inv_en     (wb_reg_write),
        .inv_id     (wb_rd_id),
        .q1_id      (q_rs1_id),
        .q2_id      (q_rs2_id),
        .head_valid (head_valid_s),
        .head_id    (head_id_s),
        .head_data  (head_data_s),
        .count      (count_s),
        .inv_match  (inv_match_s),
        .q1_match   (q1_match_s),
        .q2_match   (q2_match_s)
    );

    // Write selection: pipeline first, else queue head (invalidated head pops silently).
    always_comb begin
        we_nxt_s    = 1'b0;
        waddr_nxt_s = {ID_W{1'b0}};
        wdata_nxt_s = {DATA_W{1'b0}};
        if (wb_reg_write) begin
            we_nxt_s    = 1'b1;
            waddr_nxt_s = wb_rd_id;
            wdata_nxt_s = wb_regfile_writeback;
        end else if (pop_s && head_valid_s) begin
            we_nxt_s    = 1'b1;
            waddr_nxt_s = head_id_s;
            wdata_nxt_s = head_data_s;
        end else begin
            we_nxt_s    = 1'b0;
            waddr_nxt_s = {ID_W{1'b0}};
            wdata_nxt_s = {DATA_W{1'b0}};
        end
    end

    // Registered write port and saturating stale-drop counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we_r      <= 1'b0;
            rf_waddr_r   <= {ID_W{1'b0}};
            rf_wdata_r   <= {DATA_W{1'b0}};
            drop_count_r <= 8'd0;
        end else begin
            rf_we_r    <= we_nxt_s;
            rf_waddr_r <= waddr_nxt_s;
            rf_wdata_r <= wdata_nxt_s;
            if (drop_evt_s) begin
                drop_count_r <= sat_inc(drop_count_r);
            end
        end
    end

    // Pending lookup covers queued valid entries and the write now on the port.
    always_comb begin
        q_rs1_pending = (|q1_match_s) || (rf_we_r && (rf_waddr_r == q_rs1_id));
        q_rs2_pending = (|q2_match_s) || (rf_we_r && (rf_waddr_r == q_rs2_id));
    end

    assign rf_we       = rf_we_r;
    assign rf_waddr    = rf_waddr_r;
    assign rf_wdata    = rf_wdata_r;
    assign queue_count = count_s;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rstn;
    logic        wb_reg_write;
    logic [3:0]  wb_rd_id;
    logic [15:0] wb_regfile_writeback;
    logic        sema_wr_valid;
    logic        sema_wr_ready;
    logic [3:0]  sema_wr_rd_id;
    logic [15:0] sema_wr_data;
    logic [3:0]  q_rs1_id;
    logic [3:0]  q_rs2_id;
    logic        q_rs1_pending;
    logic        q_rs2_pending;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [2:0]  queue_count;
    logic [7:0]  drop_count;

    int vectors;
    int miscompares;

    regfile_write_arbiter dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .wb_reg_write         (wb_reg_write),
        .wb_rd_id             (wb_rd_id),
        .wb_regfile_writeback (wb_regfile_writeback),
        .sema_wr_valid        (sema_wr_valid),
        .sema_wr_ready        (sema_wr_ready),
        .sema_wr_rd_id        (sema_wr_rd_id),
        .sema_wr_data         (sema_wr_data),
        .q_rs1_id             (q_rs1_id),
        .q_rs2_id             (q_rs2_id),
        .q_rs1_pending        (q_rs1_pending),
        .q_rs2_pending        (q_rs2_pending),
        .rf_we                (rf_we),
        .rf_waddr             (rf_waddr),
        .rf_wdata             (rf_wdata),
        .queue_count          (queue_count),
        .drop_count           (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [3:0] a, input logic [15:0] d);
        check({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
        if (we) begin
            check({tag, ".addr"}, {28'd0, rf_waddr}, {28'd0, a});
            check({tag, ".data"}, {16'd0, rf_wdata}, {16'd0, d});
        end
    endtask

    task automatic wb(input logic en, input logic [3:0] rd, input logic [15:0] d);
        wb_reg_write         = en;
        wb_rd_id             = rd;
        wb_regfile_writeback = d;
    endtask

    task automatic sema(input logic en, input logic [3:0] rd, input logic [15:0] d);
        sema_wr_valid = en;
        sema_wr_rd_id = rd;
        sema_wr_data  = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        wb(1'b0, 4'd0, 16'h0000);
        sema(1'b0, 4'd0, 16'h0000);
        q_rs1_id = 4'd0;
        q_rs2_id = 4'd0;

        // Reset state
        #12;
        check("rst.we", {31'd0, rf_we}, 32'd0);
        check("rst.addr", {28'd0, rf_waddr}, 32'd0);
        check("rst.data", {16'd0, rf_wdata}, 32'd0);
        check("rst.count", {29'd0, queue_count}, 32'd0);
        check("rst.drop", {24'd0, drop_count}, 32'd0);
        check("rst.ready", {31'd0, sema_wr_ready}, 32'd1);
        #1 rstn = 1'b1;
        tick();
        check_wr("post_rst", 1'b0, 4'd0, 16'h0000);

        // Pipeline only
        wb(1'b1, 4'd3, 16'h1234);
        tick();
        wb(1'b0, 4'd0, 16'h0000);
        check_wr("pipe", 1'b1, 4'd3, 16'h1234);
        check("pipe.count", {29'd0, queue_count}, 32'd0);
        tick();
        check_wr("pipe.idle", 1'b0, 4'd0, 16'h0000);

        // Drain under idle pipeline
        sema(1'b1, 4'd5, 16'h00AA);
        tick();
        check("drain.count1", {29'd0, queue_count}, 32'd1);
        check_wr("drain.nowr", 1'b0, 4'd0, 16'h0000);
        sema(1'b1, 4'd6, 16'h0001);
        tick();
        sema(1'b0, 4'd0, 16'h0000);
        check_wr("drain.r5", 1'b1, 4'd5, 16'h00AA);
        check("drain.count2", {29'd0, queue_count}, 32'd1);
        tick();
        check_wr("drain.r6", 1'b1, 4'd6, 16'h0001);
        check("drain.count3", {29'd0, queue_count}, 32'd0);
        tick();
        check_wr("drain.idle", 1'b0, 4'd0, 16'h0000);

        // Priority and backpressure: fill while pipeline writes r1
        for (int i = 0; i < 4; i++) begin
            wb(1'b1, 4'd1, 16'h0100 + 16'(i));
            sema(1'b1, 4'd10 + 4'(i), 16'h00A0 + 16'(i));
            check("prio.ready", {31'd0, sema_wr_ready}, 32'd1);
            tick();
            check_wr("prio.pipe", 1'b1, 4'd1, 16'h0100 + 16'(i));
            check("prio.count", {29'd0, queue_count}, 32'(i + 1));
        end
        wb(1'b1, 4'd1, 16'h0199);
        sema(1'b1, 4'd14, 16'h00EE);
        #1;
        check("prio.full_ready", {31'd0, sema_wr_ready}, 32'd0);
        tick();
        check_wr("prio.full_pipe", 1'b1, 4'd1, 16'h0199);
        check("prio.full_count", {29'd0, queue_count}, 32'd4);
        wb(1'b0, 4'd0, 16'h0000);
        sema(1'b1, 4'd14, 16'h00EE);
        #1;
        check("prio.pop_ready", {31'd0, sema_wr_ready}, 32'd0);
        tick();
        sema(1'b0, 4'd0, 16'h0000);
        check_wr("prio.q0", 1'b1, 4'd10, 16'h00A0);
        check("prio.q0count", {29'd0, queue_count}, 32'd3);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_wr("prio.qn", 1'b1, 4'd10 + 4'(i), 16'h00A0 + 16'(i));
        end
        check("prio.empty", {29'd0, queue_count}, 32'd0);
        tick();
        check_wr("prio.idle", 1'b0, 4'd0, 16'h0000);

        // Stale drop
        sema(1'b1, 4'd7, 16'h1111);
        tick();
        sema(1'b0, 4'd0, 16'h0000);
        wb(1'b1, 4'd7, 16'h2222);
        tick();
        check_wr("stale.pipe1", 1'b1, 4'd7, 16'h2222);
        check("stale.drop1", {24'd0, drop_count}, 32'd1);
        check("stale.count1", {29'd0, queue_count}, 32'd1);
        sema(1'b1, 4'd7, 16'h3333);
        #1;
        check("stale.ready", {31'd0, sema_wr_ready}, 32'd1);
        tick();
        wb(1'b0, 4'd0, 16'h0000);
        sema(1'b0, 4'd0, 16'h0000);
        check_wr("stale.pipe2", 1'b1, 4'd7, 16'h2222);
        check("stale.drop2", {24'd0, drop_count}, 32'd2);
        check("stale.count2", {29'd0, queue_count}, 32'd2);
        tick();
        check_wr("stale.pop1", 1'b0, 4'd0, 16'h0000);
        check("stale.count3", {29'd0, queue_count}, 32'd1);
        tick();
        check_wr("stale.pop2", 1'b0, 4'd0, 16'h0000);
        check("stale.count4", {29'd0, queue_count}, 32'd0);
        check("stale.drop3", {24'd0, drop_count}, 32'd2);

        // Hazard query
        q_rs1_id = 4'd9;
        q_rs2_id = 4'd8;
        #1;
        check("haz.idle1", {31'd0, q_rs1_pending}, 32'd0);
        sema(1'b1, 4'd9, 16'h0909);
        tick();
        sema(1'b0, 4'd0, 16'h0000);
        check("haz.q1", {31'd0, q_rs1_pending}, 32'd1);
        check("haz.q2a", {31'd0, q_rs2_pending}, 32'd0);
        tick();
        check_wr("haz.wr", 1'b1, 4'd9, 16'h0909);
        check("haz.inflight", {31'd0, q_rs1_pending}, 32'd1);
        check("haz.q2b", {31'd0, q_rs2_pending}, 32'd0);
        tick();
        check("haz.done", {31'd0, q_rs1_pending}, 32'd0);

        // Async reset mid-drain
        for (int i = 0; i < 3; i++) begin
            wb(1'b1, 4'd2, 16'h0200);
            sema(1'b1, 4'd11 + 4'(i), 16'h0B00 + 16'(i));
            tick();
        end
        wb(1'b0, 4'd0, 16'h0000);
        sema(1'b0, 4'd0, 16'h0000);
        check("arst.count3", {29'd0, queue_count}, 32'd3);
        tick();
        check_wr("arst.drain", 1'b1, 4'd11, 16'h0B00);
        check("arst.count2", {29'd0, queue_count}, 32'd2);
        #2 rstn = 1'b0;
        #1;
        check("arst.we", {31'd0, rf_we}, 32'd0);
        check("arst.count", {29'd0, queue_count}, 32'd0);
        check("arst.drop", {24'd0, drop_count}, 32'd0);
        @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        check_wr("arst.rel1", 1'b0, 4'd0, 16'h0000);
        check("arst.rel_count", {29'd0, queue_count}, 32'd0);
        tick();
        check_wr("arst.rel2", 1'b0, 4'd0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
